// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic-unit arbiter: opcodes, FSM encoding, owner ids.
package logic_unit_arbiter_pkg;

  localparam int unsigned OP_W = 2;

  // Bitwise opcodes
  localparam logic [OP_W-1:0] OP_OR  = 2'b00;
  localparam logic [OP_W-1:0] OP_AND = 2'b01;
  localparam logic [OP_W-1:0] OP_XOR = 2'b10;
  localparam logic [OP_W-1:0] OP_NOR = 2'b11;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result / grant owner ids
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/logic_unit_arbiter_logic_unit_32.sv
// Combinational WIDTH-bit bitwise unit (OR/AND/XOR/NOR).
// Ports:
//   op       - opcode (OP_OR/OP_AND/OP_XOR/OP_NOR)
//   in0, in1 - operands
//   result_c - combinational result
module logic_unit_32
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] result_c
);

  logic [WIDTH-1:0] or_v;
  logic [WIDTH-1:0] and_v;
  logic [WIDTH-1:0] xor_v;

  // Per-bit gate arrays
  assign or_v  = in0 | in1;
  assign and_v = in0 & in1;
  assign xor_v = in0 ^ in1;

  // Opcode select
  always_comb begin
    result_c = or_v;
    case (op)
      OP_OR:   result_c = or_v;
      OP_AND:  result_c = and_v;
      OP_XOR:  result_c = xor_v;
      OP_NOR:  result_c = ~or_v;
      default: result_c = or_v;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between requesters A and B.
// Ports:
//   clock, reset (sync, active-low)
//   req_x/op_x/in0_x/in1_x - requester x operation request and operands
//   gnt_x                  - one-cycle pulse (EXEC) when x's operands were taken
//   result/result_owner    - registered result and owner (0 = A, 1 = B)
//   result_valid           - result held valid until result_ready
//   busy                   - high while an op is in EXEC or DONE
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_a,
  input  logic [OP_W-1:0]  op_a,
  input  logic [WIDTH-1:0] in0_a,
  input  logic [WIDTH-1:0] in1_a,
  input  logic             req_b,
  input  logic [OP_W-1:0]  op_b,
  input  logic [WIDTH-1:0] in0_b,
  input  logic [WIDTH-1:0] in1_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             result_owner,
  input  logic             result_ready,
  output logic             busy
);

  state_t           state_q;
  state_t           state_d;
  logic             grant_a_c;
  logic             grant_b_c;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] in0_q;
  logic [WIDTH-1:0] in1_q;
  logic             owner_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] unit_c;

  // Shared bitwise unit fed only from latched operands
  logic_unit_32 #(
    .WIDTH(WIDTH)
  ) u_unit (
    .op      (op_q),
    .in0     (in0_q),
    .in1     (in1_q),
    .result_c(unit_c)
  );

  // Next-state and round-robin grant decision
  always_comb begin
    state_d   = state_q;
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          // Tie goes to whoever did not win last
          if (last_grant_q == OWN_B) grant_a_c = 1'b1;
          else                       grant_b_c = 1'b1;
        end else if (req_a) begin
          grant_a_c = 1'b1;
        end else if (req_b) begin
          grant_b_c = 1'b1;
        end
        if (req_a || req_b) state_d = EXEC;
      end
      EXEC:    state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand latches and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_a        <= 1'b0;
      gnt_b        <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      result_owner <= OWN_A;
      op_q         <= '0;
      in0_q        <= '0;
      in1_q        <= '0;
      owner_q      <= OWN_A;
      last_grant_q <= OWN_B;
    end else begin
      state_q      <= state_d;
      gnt_a        <= grant_a_c;
      gnt_b        <= grant_b_c;
      busy         <= (state_d != IDLE);
      result_valid <= (state_d == DONE);
      if (grant_a_c) begin
        op_q         <= op_a;
        in0_q        <= in0_a;
        in1_q        <= in1_a;
        owner_q      <= OWN_A;
        last_grant_q <= OWN_A;
      end else if (grant_b_c) begin
        op_q         <= op_b;
        in0_q        <= in0_b;
        in1_q        <= in1_b;
        owner_q      <= OWN_B;
        last_grant_q <= OWN_B;
      end
      // Result captured once at the end of EXEC and held afterwards
      if (state_q == EXEC) begin
        result       <= unit_c;
        result_owner <= owner_q;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: directed cases then randomized traffic.
module tb_logic_unit_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic [1:0]  op_a, op_b;
  logic [31:0] in0_a, in1_a, in0_b, in1_b;
  logic        gnt_a, gnt_b;
  logic [31:0] result;
  logic        result_valid, result_owner, result_ready, busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        own;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];

  always #5 clock = ~clock;

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_a       (req_a),
    .op_a        (op_a),
    .in0_a       (in0_a),
    .in1_a       (in1_a),
    .req_b       (req_b),
    .op_b        (op_b),
    .in0_b       (in0_b),
    .in1_b       (in1_b),
    .gnt_a       (gnt_a),
    .gnt_b       (gnt_b),
    .result      (result),
    .result_valid(result_valid),
    .result_owner(result_owner),
    .result_ready(result_ready),
    .busy        (busy)
  );

  function automatic logic [31:0] ref_op(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present one request, hold it until granted, then record the expected result
  task automatic issue(bit who, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    int t = 0;
    bit got = 1'b0;
    if (!who) begin
      req_a = 1'b1; op_a = op; in0_a = a; in1_a = b;
    end else begin
      req_b = 1'b1; op_b = op; in0_b = a; in1_b = b;
    end
    while (!got && t < 300) begin
      @(posedge clock);
      #1;
      t++;
      got = who ? gnt_b : gnt_a;
    end
    if (got) begin
      q.push_back('{who, ref_op(op, a, b)});
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL grant_timeout: requester %0d got no grant, required one within 300 cycles", who);
    end
    // Drop request and disturb operands; the in-flight op must not notice
    if (!who) begin
      req_a = 1'b0; in0_a = $urandom; in1_a = $urandom; op_a = 2'($urandom);
    end else begin
      req_b = 1'b0; in0_b = $urandom; in1_b = $urandom; op_b = 2'($urandom);
    end
  endtask

  // Reference model: resource occupancy + round-robin memory, checked every cycle
  bit          started = 1'b0;
  bit          p_rst = 1'b0, p_ra, p_rb, p_ready, p_idle, p_valid, p_gnt;
  logic        last_m;
  logic [31:0] last_res;
  logic        last_own;

  always @(negedge clock) begin
    bit dec, w, idle_k, v_k;
    if (started) begin
      dec = 1'b0; w = 1'b0; idle_k = 1'b1; v_k = 1'b0;
      if (!p_rst) begin
        last_m = 1'b1; last_res = '0; last_own = 1'b0;
        q.delete();
      end else begin
        dec = p_idle && (p_ra || p_rb);
        w   = (p_ra && p_rb) ? !last_m : p_rb;
        if (dec) last_m = w;
        idle_k = p_idle ? !dec : (p_valid && p_ready);
        v_k    = p_gnt || (p_valid && !p_ready);
      end
      check("gnt_a", 32'(gnt_a), 32'(dec && !w));
      check("gnt_b", 32'(gnt_b), 32'(dec && w));
      check("result_valid", 32'(result_valid), 32'(v_k));
      check("busy", 32'(busy), 32'(!idle_k));
      if (v_k) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard_empty: result_valid expected with no issued op at %0t", $time);
        end else begin
          last_res = q[0].val;
          last_own = q[0].own;
          if (result_ready) void'(q.pop_front());
        end
      end
      check("result", result, last_res);
      check("result_owner", 32'(result_owner), 32'(last_own));
      p_gnt = dec; p_valid = v_k; p_idle = idle_k;
    end
    started = 1'b1;
    p_rst = reset; p_ra = req_a; p_rb = req_b; p_ready = result_ready;
  end

  task automatic do_reset();
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
  endtask

  bit rand_done = 1'b0;

  initial begin
    reset = 1'b0; result_ready = 1'b1;
    req_a = 1'b0; op_a = '0; in0_a = '0; in1_a = '0;
    req_b = 1'b0; op_b = '0; in0_b = '0; in1_b = '0;
    cyc(2);
    reset = 1'b1;

    // Single OR from A
    issue(1'b0, 2'b00, 32'hF0F0_0000, 32'h0000_0F0F);
    cyc(3);

    // Tie right after reset: A first, then B
    do_reset();
    fork
      issue(1'b0, 2'b01, 32'hFFFF_0000, 32'h0F0F_FFFF);
      issue(1'b1, 2'b10, 32'h1234_5678, 32'h0F0F_0F0F);
    join
    cyc(3);

    // Consumer stalls in DONE while B waits
    result_ready = 1'b0;
    fork
      issue(1'b0, 2'b10, 32'hDEAD_BEEF, 32'h0000_FFFF);
      begin cyc(1); issue(1'b1, 2'b01, 32'hCAFE_F00D, 32'hFF00_FF00); end
      begin cyc(8); result_ready = 1'b1; end
    join
    cyc(3);

    // NOR extremes
    issue(1'b1, 2'b11, 32'h0000_0000, 32'h0000_0000);
    issue(1'b1, 2'b11, 32'hFFFF_FFFF, 32'h0000_0000);
    cyc(3);

    // Reset during EXEC discards the op
    issue(1'b0, 2'b01, 32'hAAAA_5555, 32'hFFFF_0000);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(3);

    // Randomized contention with random consumer back-pressure
    fork
      begin
        while (!rand_done) begin
          result_ready = ($urandom_range(0, 3) != 0);
          cyc(1);
        end
      end
    join_none
    fork
      for (int i = 0; i < 40; i++) begin
        cyc($urandom_range(0, 3));
        issue(1'b0, 2'($urandom), $urandom, $urandom);
      end
      for (int j = 0; j < 40; j++) begin
        cyc($urandom_range(0, 3));
        issue(1'b1, 2'($urandom), $urandom, $urandom);
      end
    join
    rand_done = 1'b1;
    cyc(1);
    result_ready = 1'b1;
    cyc(8);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit combinational bitwise unit (OR/AND/XOR/NOR) between two requesters, A and B.
- Arbitrates round-robin, latches the winner's operands and sequences the operation through a 3-state FSM.
- Holds the registered result, tagged with its owner, until the consumer accepts it.
- Sits beside the ALU as the shared logic-op resource for the execute and multdiv paths.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset (sampled on clock edge; 0 = reset).
- req_a  in  1  requester A wants an op; held until gnt_a seen.
- op_a  in  2  A opcode: 00 OR, 01 AND, 10 XOR, 11 NOR.
- in0_a  in  WIDTH  A operand 0.
- in1_a  in  WIDTH  A operand 1.
- req_b  in  1  requester B request.
- op_b  in  2  B opcode.
- in0_b  in  WIDTH  B operand 0.
- in1_b  in  WIDTH  B operand 1.
- gnt_a  out  1  one-cycle pulse: A's operands accepted.
- gnt_b  out  1  one-cycle pulse: B's operands accepted.
- result  out  WIDTH  registered op result.
- result_valid  out  1  result valid, held until accepted.
- result_owner  out  1  0 = A, 1 = B.
- result_ready  in  1  consumer accepts result.
- busy  out  1  high in EXEC or DONE.

Behaviour:
- Reset (reset=0 at an edge), regardless of state: next cycle has state IDLE, gnt_a=gnt_b=0, result=0, result_valid=0, result_owner=0, busy=0, last_grant=B.
  - Any in-flight op is discarded; no grant or result is issued for it.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant that requester.
  - If both are high, grant the requester not equal to last_grant. After reset, A wins the first tie.
  - On a grant, at the edge: latch op, in0 and in1 of the winner plus owner; update last_grant; go to EXEC.
- EXEC (exactly one cycle):
  - gnt_<owner>=1 for this cycle only; busy=1.
  - The shared unit computes from the latched operands.
  - At the edge: result and result_owner registered; go to DONE.
- DONE:
  - result_valid=1, busy=1; result and result_owner are stable.
  - If result_ready=1 at the edge: go to IDLE and result_valid drops next cycle.
  - result keeps its last value after DONE; only result_valid clears.
  - Requests arriving during EXEC or DONE wait; no grant is given outside EXEC.
- Latency: request sampled at edge N → gnt in cycle N+1 → result_valid in cycle N+2. Minimum issue interval is 3 cycles (result_ready tied high).
- Handshake rules:
  - A requester holds req and its operands stable until it sees gnt.
  - A req still high in the cycle after gnt counts as a new request.
  - Operand changes after acceptance do not affect the in-flight result.
- Arithmetic: pure bitwise per bit i.
  - OR: in0|in1. AND: in0&in1. XOR: in0^in1. NOR: ~(in0|in1).
  - No carry, no flags.
- Simultaneous events:
  - reset=0 together with result_ready or req: reset wins.
  - result_ready while result_valid=0 is ignored.

Decomposition:
- Shared package holds:
  - opcode constants OP_OR=2'b00, OP_AND=2'b01, OP_XOR=2'b10, OP_NOR=2'b11;
  - state encoding IDLE=2'd0, EXEC=2'd1, DONE=2'd2;
  - owner constants OWN_A=0, OWN_B=1.
- One natural sub-module: logic_unit_32, a combinational WIDTH-bit bitwise unit (op, in0, in1 → out) built from the existing per-bit gate arrays.
- The arbiter, FSM and registers stay in the top block.

Test Plan:
- Reset then req_a=1, op_a=00, in0_a=32'hF0F0_0000, in1_a=32'h0000_0F0F, result_ready=1 → gnt_a in cycle 1; cycle 2: result_valid=1, result=32'hF0F0_0F0F, result_owner=0.
- Both req from IDLE after reset, A op=01 (32'hFFFF_0000 & 32'h0F0F_FFFF), B op=10 → A first (result 32'h0F0F_0000); then B granted next, owner=1, XOR value correct.
- result_ready=0 for 5 cycles in DONE → result_valid and result stable; no gnt pulses despite req_b=1; then ready=1 → IDLE, then B granted.
- Op NOR with in0=in1=32'h0000_0000 → result 32'hFFFF_FFFF; in0=32'hFFFF_FFFF → 32'h0000_0000.
- reset=0 asserted during EXEC → next cycle IDLE; result_valid=0, result=0, busy=0; no result ever appears for that op.
- Change in0_a the cycle after gnt_a → result reflects the original latched operands.
